lcd_scanner: RTL

LCD_SCANNER -- requirements
Module: lcd_scanner

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_scanner_if.sv | 10 +
 rtl/lcd_scanner_frame_store.sv | 36 +++
 rtl/lcd_scanner.sv | 84 ++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and address layout for the LCD segment scanner.
// A frame is stored row-major per common line: bit index = {h, bank, seg}.
package lcd_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, COMMIT} state_e;

   localparam int NUM_H         = 4;
   localparam int NUM_SEG       = 16;
   localparam int ROW_W         = 2 * NUM_SEG;
   localparam int FRAME_W       = NUM_H * ROW_W;
   localparam int ADDR_W        = 7;
   localparam int ADDR_SEG_LSB  = 0;
   localparam int ADDR_SEG_MSB  = 3;
   localparam int ADDR_H_LSB    = 4;
   localparam int ADDR_H_MSB    = 5;
   localparam int ADDR_BANK_BIT = 6;

   // rd_addr is {bank, h, seg}; storage rows are {bank B, bank A} per h.
   function automatic logic [ADDR_W-1:0] frame_idx(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_H_MSB:ADDR_H_LSB], addr[ADDR_BANK_BIT], addr[ADDR_SEG_MSB:ADDR_SEG_LSB]};
   endfunction
endpackage

// File: rtl/lcd_scanner_if.sv
// Frame read port: one request per cycle, data returned one cycle later.
interface lcd_rd_if;
   logic       rd_req;
   logic [6:0] rd_addr;
   logic       rd_valid;
   logic       rd_data;

   modport master (output rd_req, rd_addr, input rd_valid, rd_data);
   modport slave  (input rd_req, rd_addr, output rd_valid, rd_data);
endinterface

// File: rtl/lcd_scanner_frame_store.sv
// Committed frame buffer: atomic 128-bit load, 1-cycle registered bit read.
module lcd_frame_store
   import lcd_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [FRAME_W-1:0] load_data,
   lcd_rd_if.slave            rd
);
   logic [FRAME_W-1:0] frame_d, frame_q;
   logic               rd_valid_d, rd_valid_q;
   logic               rd_data_d, rd_data_q;

   // Read uses frame_q, so a read on the load cycle returns the old frame.
   always_comb begin
      frame_d    = load ? load_data : frame_q;
      rd_valid_d = rd.rd_req;
      rd_data_d  = rd.rd_req ? frame_q[frame_idx(rd.rd_addr)] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 1'b0;
      end else begin
         frame_q    <= frame_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd.rd_valid = rd_valid_q;
   assign rd.rd_data  = rd_data_q;
endmodule

// File: rtl/lcd_scanner.sv
// Steps the common line on each accepted tick, samples both segment banks
// after a settle delay, and commits a full 4-row frame atomically.
module lcd_scanner
   import lcd_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tick,
   input  logic         lcd_on,
   input  logic [15:0]  segment_a,
   input  logic [15:0]  segment_b,
   output logic [1:0]   lcd_h,
   output logic         frame_done,
   lcd_rd_if.slave      rd
);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_e                        state_d, state_q;
   logic [3:0]                    cnt_d, cnt_q;
   logic [1:0]                    lcd_h_d, lcd_h_q;
   logic                          frame_done_d, frame_done_q;
   logic [NUM_H-1:0][ROW_W-1:0]   shadow_d, shadow_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lcd_h_d      = lcd_h_q;
      shadow_d     = shadow_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: if (tick) begin
            state_d = SETTLE;
            cnt_d   = '0;
         end
         SETTLE: if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
                 else                      cnt_d   = cnt_q + 4'd1;
         SAMPLE: begin
            shadow_d[lcd_h_q] = lcd_on ? {segment_b, segment_a} : '0;
            // frame_done is registered, so raise it on entry to COMMIT.
            if (lcd_h_q == 2'(NUM_H - 1)) begin
               state_d      = COMMIT;
               frame_done_d = 1'b1;
            end else begin
               lcd_h_d = lcd_h_q + 2'd1;
               state_d = IDLE;
            end
         end
         COMMIT: begin
            lcd_h_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         lcd_h_q      <= '0;
         frame_done_q <= 1'b0;
         shadow_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lcd_h_q      <= lcd_h_d;
         frame_done_q <= frame_done_d;
         shadow_q     <= shadow_d;
      end
   end

   assign lcd_h      = lcd_h_q;
   assign frame_done = frame_done_q;

   lcd_frame_store u_store (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (state_q == COMMIT),
      .load_data (shadow_q),
      .rd        (rd)
   );
endmodule
